div_unit: RTL

Iterative radix-2 restoring divider for the execute stage of the 5-stage LoongArch pipeline, serving DIV.W/MOD.W/DIV.WU/MOD.WU. It drives the divide-busy bit of the execute-to-hazard bus: the hazard unit uses this bit to hold IF/ID/EX and bubble MEM. The unit accepts stall and flush back from the hazard unit so a finished or aborted divide never restarts or leaks a result.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared divider definitions: FSM encodings, default width and the position of
// the divide-busy bit on the execute-to-hazard bus.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // ES_TO_HAZARD_BUS = {es_load_pending, es_div_stall}
    localparam int unsigned ES_TO_HAZARD_BUS_W = 2;
    localparam int unsigned ES_DIV_STALL_BIT   = 0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract
// the divisor when it fits, and emit the quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_msb,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;

    // The shifted remainder needs WIDTH+1 bits so divisors above 2^(WIDTH-1) work.
    assign w_shift = {i_rem, i_dvd_msb};
    assign o_qbit  = (w_shift >= {1'b0, i_dvs});
    // When the divisor fits, the difference is below 2^WIDTH, so the low bits are exact.
    assign w_sub   = w_shift[WIDTH-1:0] - i_dvs;
    assign o_rem   = o_qbit ? w_sub : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for EX: DIV.W/MOD.W/DIV.WU/MOD.WU, one quotient
// bit per cycle, with hazard-unit stall/flush handshake.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_valid,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             es_stall,
    input  logic             es_flush,
    output logic             div_stall,
    output logic             div_done,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_dvd, w_dvd_nxt;
    logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic             r_qneg, w_qneg_nxt;
    logic             r_rneg, w_rneg_nxt;

    logic             w_s1, w_s2, w_start;
    logic [WIDTH-1:0] w_abs1, w_abs2;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_qbit;

    assign w_s1    = div_signed & div_src1[WIDTH-1];
    assign w_s2    = div_signed & div_src2[WIDTH-1];
    assign w_abs1  = w_s1 ? -div_src1 : div_src1;
    assign w_abs2  = w_s2 ? -div_src2 : div_src2;
    assign w_start = div_valid & ~es_flush;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_dvd_msb (r_dvd[WIDTH-1]),
        .i_dvs     (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dvd   <= w_dvd_nxt;
            r_dvs   <= w_dvs_nxt;
            r_rem   <= w_rem_nxt;
            r_qneg  <= w_qneg_nxt;
            r_rneg  <= w_rneg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dvd_nxt   = r_dvd;
        w_dvs_nxt   = r_dvs;
        w_rem_nxt   = r_rem;
        w_qneg_nxt  = r_qneg;
        w_rneg_nxt  = r_rneg;
        unique case (r_state)
            DIV_IDLE: begin
                if (w_start) begin
                    w_state_nxt = DIV_BUSY;
                    w_cnt_nxt   = '0;
                    w_dvd_nxt   = w_abs1;
                    w_dvs_nxt   = w_abs2;
                    w_rem_nxt   = '0;
                    w_qneg_nxt  = w_s1 ^ w_s2;
                    w_rneg_nxt  = w_s1;
                end
            end
            DIV_BUSY: begin
                // Dividend bits shift out the top while quotient bits fill from the bottom.
                w_rem_nxt = w_step_rem;
                w_dvd_nxt = {r_dvd[WIDTH-2:0], w_step_qbit};
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DIV_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DIV_DONE: begin
                if (!es_stall) begin
                    w_state_nxt = DIV_IDLE;
                end
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
        if (es_flush) begin
            w_state_nxt = DIV_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    assign div_stall     = ((r_state == DIV_IDLE) & w_start) | (r_state == DIV_BUSY);
    assign div_done      = (r_state == DIV_DONE);
    assign div_quotient  = div_done ? (r_qneg ? -r_dvd : r_dvd) : '0;
    assign div_remainder = div_done ? (r_rneg ? -r_rem : r_rem) : '0;

endmodule
